univ_shift_reg: RTL

Parametrised universal shift register built from edge-triggered storage with asynchronous reset. It supports parallel load, clear, logical and arithmetic shifts, and rotates. Each multi-bit shift runs as a burst, one bit per clock, under a START/BUSY/DONE handshake. It sits in the datapath as a general-purpose serialiser, deserialiser and barrel-shift substitute, next to the existing single-bit flip-flop storage.

---
 rtl/usr_pkg.sv | 52 +++++
 rtl/usr_ctrl.sv | 89 ++++++++
 rtl/univ_shift_reg.sv | 72 +++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings, FSM
// states and a single-step shift/rotate function usable by RTL and models.
package usr_pkg;

  localparam int USR_MAXW = 64;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [2:0] mode);
    return (mode != MODE_HOLD) && (mode != MODE_LOAD) && (mode != MODE_CLR);
  endfunction

  // Returns {q_next, sout} for one step on a register of 'width' bits held in
  // the low bits of q; bits at and above 'width' in the result are zero.
  function automatic logic [USR_MAXW:0] usr_step(input logic [2:0] mode,
                                                 input logic [USR_MAXW-1:0] q,
                                                 input logic sin,
                                                 input int unsigned width);
    logic [USR_MAXW-1:0] mask;
    logic [USR_MAXW-1:0] msb_mask;
    logic [USR_MAXW-1:0] qn;
    logic                msb;
    logic                so;
    msb_mask = USR_MAXW'(1) << (width - 1);
    mask     = (width >= USR_MAXW) ? '1 : ((USR_MAXW'(1) << width) - USR_MAXW'(1));
    msb      = |(q & msb_mask);
    qn       = q;
    so       = 1'b0;
    case (mode)
      MODE_SHL: begin qn = (q << 1) | USR_MAXW'(sin);           so = msb;  end
      MODE_SHR: begin qn = (q >> 1) | (sin ? msb_mask : '0);    so = q[0]; end
      MODE_ROL: begin qn = (q << 1) | USR_MAXW'(msb);           so = msb;  end
      MODE_ROR: begin qn = (q >> 1) | (q[0] ? msb_mask : '0);   so = q[0]; end
      MODE_ASR: begin qn = (q >> 1) | (msb ? msb_mask : '0);    so = q[0]; end
      default:  begin qn = q;                                   so = 1'b0; end
    endcase
    return {qn & mask, so};
  endfunction

endpackage

// File: rtl/usr_ctrl.sv
// Burst controller: accepts requests while idle, clamps the step count and
// issues one operation enable per step together with the mode to apply.
module usr_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [2:0]    i_mode,
  input  logic [AW-1:0] i_amount,
  output logic          o_op_en,
  output logic [2:0]    o_op_mode,
  output logic          o_busy,
  output logic          o_done,
  output state_t        o_state
);

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_next;
  logic [2:0]    r_mode;
  logic [2:0]    w_mode_next;
  logic          r_done;
  logic          w_done_next;
  logic [AW-1:0] w_amt;

  // Handshake: i_start is sampled only in ST_IDLE; o_busy is high for every
  // cycle spent in ST_RUN and o_done pulses one cycle after the final step.
  always_comb begin
    w_amt        = (i_amount > AW'(WIDTH)) ? AW'(WIDTH) : i_amount;
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_mode_next  = r_mode;
    w_done_next  = 1'b0;
    o_op_en      = 1'b0;
    o_op_mode    = r_mode;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          o_op_mode   = i_mode;
          w_mode_next = i_mode;
          if (!is_shift(i_mode)) begin
            o_op_en     = 1'b1;
            w_done_next = 1'b1;
          end else if (w_amt == '0) begin
            w_done_next = 1'b1;
          end else begin
            o_op_en    = 1'b1;
            w_cnt_next = w_amt - AW'(1);
            if (w_amt > AW'(1)) w_next_state = ST_RUN;
            else                w_done_next  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        o_op_en    = 1'b1;
        w_cnt_next = r_cnt - AW'(1);
        if (r_cnt == AW'(1)) begin
          w_next_state = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_mode  <= w_mode_next;
      r_done  <= w_done_next;
    end
  end

  assign o_busy  = (r_state == ST_RUN);
  assign o_done  = r_done;
  assign o_state = r_state;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, clear, shifts and rotates run as
// one-bit-per-clock bursts under a START/BUSY/DONE handshake.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  input  logic [AW-1:0]    i_amount,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout,
  output logic             o_busy,
  output logic             o_done,
  output state_t           o_state
);

  logic [WIDTH-1:0]  r_q;
  logic              r_sout;
  logic              w_op_en;
  logic [2:0]        w_op_mode;
  logic [USR_MAXW:0] w_step;
  logic [WIDTH-1:0]  w_q_next;
  logic              w_sout_next;

  usr_ctrl #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ctrl (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_mode    (i_mode),
    .i_amount  (i_amount),
    .o_op_en   (w_op_en),
    .o_op_mode (w_op_mode),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_state   (o_state)
  );

  assign w_step      = usr_step(w_op_mode, USR_MAXW'(r_q), i_sin, WIDTH);
  assign w_q_next    = WIDTH'(w_step >> 1);
  assign w_sout_next = w_step[0];

  // SOUT only moves on shift/rotate steps; LOAD/CLR/HOLD keep its last value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q    <= '0;
      r_sout <= 1'b0;
    end else if (w_op_en) begin
      case (w_op_mode)
        MODE_HOLD: r_q <= r_q;
        MODE_LOAD: r_q <= i_d;
        MODE_CLR:  r_q <= '0;
        default: begin
          r_q    <= w_q_next;
          r_sout <= w_sout_next;
        end
      endcase
    end
  end

  assign o_q    = r_q;
  assign o_sout = r_sout;

endmodule
